ads1672_frame_reader: RTL

ADS1672_FRAME_READER -- requirements
Module: ads1672_frame_reader

---
 rtl/ads1672_pkg.sv | 13 +
 rtl/sync_2ff.sv | 28 ++
 rtl/ads1672_frame_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ads1672_pkg.sv
// Shared types and ADS1672 default parameters for the frame reader.
package ads1672_pkg;

  localparam int unsigned ADS_DATA_WIDTH = 24;
  localparam int unsigned ADS_SCLK_HALF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterized two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int unsigned          WIDTH   = 1,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ads1672_frame_reader.sv
// Reads one serial conversion frame from an ADS1672 per DRDY falling edge
// and presents it on a valid/ready sample port with sticky overrun.
module ads1672_frame_reader
  import ads1672_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ADS_DATA_WIDTH,
  parameter int unsigned SCLK_HALF  = ADS_SCLK_HALF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  drdy_n,
  input  logic                  dout,
  output logic                  sclk,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic drdy_s;
  logic dout_s;
  logic drdy_prev_q;
  logic drdy_fall;
  logic tick;

  state_e                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  sclk_q, sclk_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_drdy (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (drdy_n),
    .q_o   (drdy_s)
  );

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_dout (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dout),
    .q_o   (dout_s)
  );

  assign drdy_fall = drdy_prev_q & ~drdy_s;
  assign tick      = (div_q == DIV_W'(SCLK_HALF - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start on a qualified DRDY edge, finish after the last captured bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (drdy_fall && enable) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick && sclk_q && (bit_cnt_q == CNT_W'(DATA_WIDTH - 1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: SCLK divider, bit capture on falling SCLK, sample handoff.
  always_comb begin
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (valid_q && sample_ready) valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        div_d     = '0;
        bit_cnt_d = '0;
        sclk_d    = 1'b0;
      end
      ST_SHIFT: begin
        if (tick) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shreg_d   = {shreg_q[DATA_WIDTH-2:0], dout_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        div_d  = '0;
        sclk_d = 1'b0;
        if (!valid_q || sample_ready) begin
          sample_d = shreg_q;
          valid_d  = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        sclk_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drdy_prev_q <= 1'b1;
      div_q       <= '0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      shreg_q     <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      drdy_prev_q <= drdy_s;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      shreg_q     <= shreg_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sclk         = sclk_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign busy         = busy_q;

endmodule
